// File: rtl/flow_table_flush_ctrl_pkg.sv
// flow_table_flush_ctrl_pkg: controller state encoding and flow-table geometry
package flow_table_flush_ctrl_pkg;
  localparam int FLOW_TABLE_DEPTH = 32;
  localparam int FLOW_ADDR_WIDTH = 5;
  localparam int FLOW_ENTRY_WIDTH = 64;
  localparam int FLOW_ACK_TIMEOUT = 255;
  typedef enum logic [2:0] {IDLE, UPD, DRAIN, CLEAR, DONE, ABORT} flush_state_t;
endpackage

// File: rtl/flow_table_flush_ctrl_if.sv
// flow_table_flush_ctrl_if: flush request, flow-update and table-write port bundle
interface flow_table_flush_ctrl_if
  import flow_table_flush_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = FLOW_ADDR_WIDTH,
  parameter int DATA_WIDTH = FLOW_ENTRY_WIDTH
);
  logic flush_req;
  logic upd_req;
  logic [ADDR_WIDTH-1:0] upd_addr;
  logic [DATA_WIDTH-1:0] upd_data;
  logic upd_ack;
  logic tbl_wr_req;
  logic [ADDR_WIDTH-1:0] tbl_wr_addr;
  logic [DATA_WIDTH-1:0] tbl_wr_data;
  logic tbl_wr_ack;
  logic lookup_hold;
  logic flush_busy;
  logic flush_done;
  logic flush_error;
  modport master (
    input flush_req, upd_req, upd_addr, upd_data, tbl_wr_ack,
    output upd_ack, tbl_wr_req, tbl_wr_addr, tbl_wr_data, lookup_hold, flush_busy, flush_done, flush_error
  );
  modport slave (
    output flush_req, upd_req, upd_addr, upd_data, tbl_wr_ack,
    input upd_ack, tbl_wr_req, tbl_wr_addr, tbl_wr_data, lookup_hold, flush_busy, flush_done, flush_error
  );
endinterface

// File: rtl/flow_table_flush_ctrl_ack_timer.sv
// flush_ack_timer: loadable down-counter that flags expiry on the enabled step that reaches zero
module flush_ack_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);
  logic [WIDTH-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign expire = en && !load && cnt == WIDTH'(1);
endmodule

// File: rtl/flow_table_flush_ctrl.sv
// flow_table_flush_ctrl: clears the flow table on a watchdog flush and arbitrates its write port
module flow_table_flush_ctrl
  import flow_table_flush_ctrl_pkg::*;
#(
  parameter int TABLE_DEPTH = FLOW_TABLE_DEPTH,
  parameter int ADDR_WIDTH = FLOW_ADDR_WIDTH,
  parameter int DATA_WIDTH = FLOW_ENTRY_WIDTH,
  parameter int ACK_TIMEOUT = FLOW_ACK_TIMEOUT
) (
  input logic clk,
  input logic reset,
  flow_table_flush_ctrl_if.master bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  flush_state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic pending, pending_n, waiting, expire, last;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      pending <= 1'b0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      pending <= pending_n;
    end
  assign waiting = bus.tbl_wr_req && !bus.tbl_wr_ack;
  assign last = addr == ADDR_WIDTH'(TABLE_DEPTH - 1);
  flush_ack_timer #(.WIDTH(TW)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(!waiting),
    .en(waiting),
    .load_val(TW'(ACK_TIMEOUT)),
    .expire(expire)
  );
  always_comb begin
    state_n = state;
    addr_n = addr;
    pending_n = pending || (bus.flush_req && state != IDLE);
    case (state)
      IDLE: state_n = (bus.flush_req || pending) ? DRAIN : bus.upd_req ? UPD : IDLE;
      UPD: state_n = (bus.tbl_wr_ack || expire) ? IDLE : UPD;
      DRAIN: begin
        state_n = CLEAR;
        addr_n = '0;
      end
      CLEAR: begin
        state_n = expire ? ABORT : (bus.tbl_wr_ack && last) ? DONE : CLEAR;
        addr_n = (bus.tbl_wr_ack && !last) ? addr + 1'b1 : addr;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == DRAIN) pending_n = 1'b0;
  end
  assign bus.tbl_wr_req = state == UPD || state == CLEAR;
  assign bus.tbl_wr_addr = state == UPD ? bus.upd_addr : addr;
  assign bus.tbl_wr_data = state == UPD ? bus.upd_data : {DATA_WIDTH{1'b0}};
  assign bus.upd_ack = state == UPD && bus.tbl_wr_ack;
  assign bus.flush_busy = state == DRAIN || state == CLEAR;
  assign bus.lookup_hold = state == DRAIN || state == CLEAR;
  assign bus.flush_done = state == DONE;
  assign bus.flush_error = state == ABORT;
endmodule

// File: tb/tb_flow_table_flush_ctrl.sv
// tb_flow_table_flush_ctrl: directed checks of flush walk, arbitration, pending, timeout and reset
module tb_flow_table_flush_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  flow_table_flush_ctrl_if bus();
  flow_table_flush_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  logic [63:0] mem [32];
  logic [4:0] log_a [$];
  logic [63:0] log_d [$];
  int done_cnt = 0, err_cnt = 0, upd_ack_cnt = 0, done_at_ack = 0, stab_err = 0;
  int wcnt = 0, dly = 0, stall_addr = -1;
  bit rand_mode = 0;
  logic p_req = 1'b0, p_ack = 1'b0;
  logic [4:0] p_addr = '0;
  logic [63:0] p_data = '0;

  // table model: decides the ack at the falling edge, then observes settled outputs
  always @(negedge clk) begin
    bus.tbl_wr_ack = 1'b0;
    if (!reset && bus.tbl_wr_req && !(bus.flush_busy && int'(bus.tbl_wr_addr) == stall_addr)) begin
      if (wcnt >= dly) begin
        bus.tbl_wr_ack = 1'b1;
        wcnt = 0;
        dly = rand_mode ? int'($urandom_range(20, 0)) : 0;
      end else wcnt++;
    end else wcnt = 0;
    #2;
    if (!reset) begin
      if (bus.tbl_wr_req && bus.tbl_wr_ack) begin
        mem[bus.tbl_wr_addr] = bus.tbl_wr_data;
        log_a.push_back(bus.tbl_wr_addr);
        log_d.push_back(bus.tbl_wr_data);
      end
      if (p_req && !p_ack && bus.tbl_wr_req && (bus.tbl_wr_addr !== p_addr || bus.tbl_wr_data !== p_data)) stab_err++;
      if (bus.flush_done) done_cnt++;
      if (bus.flush_error) err_cnt++;
      if (bus.upd_ack) begin
        upd_ack_cnt++;
        done_at_ack = done_cnt;
      end
    end
    p_req = bus.tbl_wr_req;
    p_ack = bus.tbl_wr_ack;
    p_addr = bus.tbl_wr_addr;
    p_data = bus.tbl_wr_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_flush();
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.flush_done && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_addr(string tag, int a);
    int n = 0;
    while (!(bus.tbl_wr_req && bus.flush_busy && int'(bus.tbl_wr_addr) == a) && n < 1000) begin
      tick();
      n++;
    end
    check(tag, n < 1000, 1);
  endtask

  task automatic wait_upd(string tag, int target);
    int n = 0;
    while (upd_ack_cnt < target && n < 1000) begin
      tick();
      n++;
    end
    check(tag, upd_ack_cnt, target);
  endtask

  task automatic check_walk(string tag, int base);
    int bad = 0;
    for (int i = 0; i < 32; i++)
      if (log_a.size() <= base + i || log_a[base + i] != 5'(i) || log_d[base + i] != 64'd0) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    int n, base_done, base_err, nz;
    bus.flush_req = 1'b0;
    bus.upd_req = 1'b0;
    bus.upd_addr = '0;
    bus.upd_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = '1;
    tick();
    tick();
    check("rst_outputs", {bus.tbl_wr_req, bus.upd_ack, bus.flush_busy, bus.lookup_hold, bus.flush_done, bus.flush_error}, 0);
    check("rst_addr", bus.tbl_wr_addr, 0);
    reset = 1'b0;
    tick();

    log_a.delete(); log_d.delete();
    pulse_flush();
    check("t1_drain_busy_hold", {bus.flush_busy, bus.lookup_hold, bus.tbl_wr_req}, 3'b110);
    tick();
    check("t1_first_req", {bus.tbl_wr_req, bus.tbl_wr_addr}, {1'b1, 5'd0});
    wait_done(n);
    check("t1_walk_cycles", n, 32);
    tick();
    check("t1_done_count", done_cnt, 1);
    check("t1_no_error", err_cnt, 0);
    check("t1_idle_outputs", {bus.flush_busy, bus.lookup_hold, bus.tbl_wr_req, bus.flush_done}, 0);
    check("t1_writes", log_a.size(), 32);
    check_walk("t1_walk_order", 0);
    nz = 0;
    for (int i = 0; i < 32; i++) if (mem[i] != 64'd0) nz++;
    check("t1_table_cleared", nz, 0);

    log_a.delete(); log_d.delete();
    pulse_flush();
    wait_addr("t2_reach_addr10", 10);
    bus.upd_req = 1'b1;
    bus.upd_addr = 5'd5;
    bus.upd_data = 64'hDEAD_BEEF_0000_0005;
    wait_upd("t2_upd_ack", 1);
    bus.upd_req = 1'b0;
    check("t2_ack_after_done", done_at_ack, 2);
    check("t2_entry5", mem[5], 64'hDEAD_BEEF_0000_0005);
    check("t2_writes", log_a.size(), 33);
    check("t2_last_write_addr", log_a[log_a.size() - 1], 5);
    check_walk("t2_walk_order", 0);

    log_a.delete(); log_d.delete();
    bus.flush_req = 1'b1;
    bus.upd_req = 1'b1;
    bus.upd_addr = 5'd3;
    bus.upd_data = 64'h0000_0000_CAFE_0003;
    tick();
    bus.flush_req = 1'b0;
    check("t3_flush_wins", {bus.flush_busy, bus.tbl_wr_req}, 2'b10);
    wait_upd("t3_upd_ack", 2);
    bus.upd_req = 1'b0;
    check("t3_upd_after_flush", done_at_ack, 3);
    check("t3_entry3", mem[3], 64'h0000_0000_CAFE_0003);
    check("t3_writes", log_a.size(), 33);
    check_walk("t3_walk_order", 0);

    log_a.delete(); log_d.delete();
    base_done = done_cnt;
    pulse_flush();
    repeat (4) tick();
    pulse_flush();
    repeat (2) tick();
    pulse_flush();
    repeat (2) tick();
    pulse_flush();
    n = 0;
    while (done_cnt < base_done + 2 && n < 1000) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check("t3_two_walks_done", done_cnt, base_done + 2);
    check("t3_two_walks_writes", log_a.size(), 64);
    check_walk("t3_walk1", 0);
    check_walk("t3_walk2", 32);
    check("t3_idle_after", bus.flush_busy, 0);

    log_a.delete(); log_d.delete();
    stall_addr = 7;
    base_done = done_cnt;
    base_err = err_cnt;
    pulse_flush();
    wait_addr("t4_reach_addr7", 7);
    n = 0;
    while (!bus.flush_error && n < 1000) begin
      tick();
      n++;
    end
    check("t4_timeout_cycles", n, 255);
    check("t4_abort_outputs", {bus.tbl_wr_req, bus.flush_busy, bus.lookup_hold, bus.flush_done}, 0);
    tick();
    stall_addr = -1;
    check("t4_error_count", err_cnt, base_err + 1);
    check("t4_error_pulse", bus.flush_error, 0);
    check("t4_no_done", done_cnt, base_done);
    check("t4_partial_writes", log_a.size(), 7);
    check("t4_idle", {bus.tbl_wr_req, bus.flush_busy}, 0);

    pulse_flush();
    wait_addr("t5_reach_addr10", 10);
    pulse_flush();
    wait_addr("t5_reach_addr12", 12);
    reset = 1'b1;
    tick();
    check("t5_reset_outputs", {bus.tbl_wr_req, bus.upd_ack, bus.flush_busy, bus.lookup_hold, bus.flush_done, bus.flush_error}, 0);
    check("t5_reset_addr", bus.tbl_wr_addr, 0);
    reset = 1'b0;
    repeat (3) tick();
    check("t5_pending_lost", {bus.flush_busy, bus.tbl_wr_req}, 0);
    log_a.delete(); log_d.delete();
    pulse_flush();
    tick();
    check("t5_restart_addr0", {bus.tbl_wr_req, bus.tbl_wr_addr}, {1'b1, 5'd0});
    wait_done(n);
    tick();
    check("t5_restart_writes", log_a.size(), 32);
    check_walk("t5_walk_order", 0);

    rand_mode = 1;
    log_a.delete(); log_d.delete();
    stab_err = 0;
    base_done = done_cnt;
    pulse_flush();
    wait_done(n);
    tick();
    rand_mode = 0;
    check("t6_done", done_cnt, base_done + 1);
    check("t6_stable", stab_err, 0);
    check("t6_writes", log_a.size(), 32);
    check_walk("t6_walk_order", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
